// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default header tag and an index-width helper.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [3:0] HDR_TAG_DEF = 4'hA;

  // Index width for n entries, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_arbiter.sv
// Combinational round-robin pick: first set request bit searching from
// ptr_i upward, wrapping modulo N.
//  req_i  in   N   request vector
//  ptr_i  in   IW  search start index
//  idx_o  out  IW  index of the selected requester
//  any_o  out  1   at least one request present
module rr_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [N-1:0] gnt;
  logic [IW:0]  sum;
  logic         found;

  always_comb begin
    gnt   = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      if (!found && req_i[sum[IW-1:0]]) begin
        found              = 1'b1;
        gnt[sum[IW-1:0]]   = 1'b1;
        idx_o              = sum[IW-1:0];
      end
    end
  end

  assign any_o = |gnt;

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter sharing one UART TX input between
// N_REQ byte-stream sources. A grant lasts one packet, optionally preceded
// by a {HDR_TAG, id} header byte; over-long or stalled grants are released.
//  clk, rst     clock, synchronous active-high reset
//  req_data     in   8*N_REQ  source bytes, source i at [8*i+7:8*i]
//  req_valid    in   N_REQ    source byte valid
//  req_last     in   N_REQ    source byte ends its packet
//  req_ready    out  N_REQ    source byte accepted (valid & ready)
//  uart_data    out  8        byte to UART
//  uart_valid   out  1        byte valid to UART
//  uart_ready   in   1        UART accepts byte
//  grant_id     out  IDW      current / most recent grantee
//  busy         out  1        header or data phase active
//  timeout_err  out  N_REQ    one-cycle pulse when source lost grant by stall
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter  int unsigned N_REQ   = 4,
  parameter  bit          HDR_EN  = 1'b1,
  parameter  logic [3:0]  HDR_TAG = HDR_TAG_DEF,
  parameter  int unsigned MAX_PKT = 64,
  parameter  int unsigned TIMEOUT = 1000,
  localparam int unsigned IDW     = clog2_min1(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         uart_data,
  output logic               uart_valid,
  input  logic               uart_ready,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic [N_REQ-1:0]   timeout_err
);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [7:0]     bcnt_q, bcnt_d;
  logic [15:0]    scnt_q, scnt_d;

  logic [IDW-1:0] arb_idx;
  logic           arb_any;
  logic [IDW:0]   gid_inc;
  logic [IDW-1:0] ptr_next;
  logic [3:0]     hdr_id;
  logic           g_valid, g_last;
  logic [7:0]     g_data;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign gid_inc  = {1'b0, gid_q} + (IDW+1)'(1);
  assign ptr_next = (gid_inc == (IDW+1)'(N_REQ)) ? '0 : gid_inc[IDW-1:0];
  assign hdr_id   = 4'(gid_q);
  assign g_valid  = req_valid[gid_q];
  assign g_last   = req_last[gid_q];
  assign g_data   = req_data[{gid_q, 3'b000} +: 8];
  assign grant_id = gid_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    bcnt_d      = bcnt_q;
    scnt_d      = scnt_q;
    req_ready   = '0;
    uart_valid  = 1'b0;
    uart_data   = '0;
    timeout_err = '0;
    busy        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gid_d   = arb_idx;
          bcnt_d  = '0;
          scnt_d  = '0;
          state_d = HDR_EN ? ST_HDR : ST_DATA;
        end
      end
      ST_HDR: begin
        busy       = 1'b1;
        uart_valid = 1'b1;
        uart_data  = {HDR_TAG, hdr_id};
        if (uart_ready) state_d = ST_DATA;
      end
      ST_DATA: begin
        busy             = 1'b1;
        uart_valid       = g_valid;
        uart_data        = g_data;
        req_ready[gid_q] = uart_ready;
        if (g_valid) begin
          scnt_d = '0;
          if (uart_ready) begin
            bcnt_d = bcnt_q + 8'd1;
            if (g_last || bcnt_d == 8'(MAX_PKT)) begin
              state_d = ST_IDLE;
              ptr_d   = ptr_next;
            end
          end
        end else if (scnt_q == 16'(TIMEOUT - 1)) begin
          timeout_err[gid_q] = 1'b1;
          scnt_d             = '0;
          state_d            = ST_IDLE;
          ptr_d              = ptr_next;
        end else begin
          scnt_d = scnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are combinational from state, so suppress them while reset is
    // asserted to guarantee no handshake completes in the reset cycle.
    if (rst) begin
      req_ready   = '0;
      uart_valid  = 1'b0;
      uart_data   = '0;
      timeout_err = '0;
      busy        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      bcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last  = '0;
  logic [3:0]  req_ready;
  logic [7:0]  uart_data;
  logic        uart_valid;
  logic        uart_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic [3:0]  timeout_err;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;

  logic [8:0] srcq[4][$];
  logic [7:0] expq[$];

  uart_tx_arb #(
    .N_REQ  (4),
    .HDR_EN (1'b1),
    .HDR_TAG(4'hA),
    .MAX_PKT(4),
    .TIMEOUT(10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .uart_data  (uart_data),
    .uart_valid (uart_valid),
    .uart_ready (uart_ready),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Source models: present queue heads, pop on handshake seen at the edge.
  always @(posedge clk) begin
    logic [3:0] tk;
    tk = req_valid & req_ready;
    #2;
    for (int i = 0; i < 4; i++) begin
      if (tk[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      if (srcq[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_last[i]         = srcq[i][0][8];
        req_data[8*i +: 8]  = srcq[i][0][7:0];
      end else begin
        req_valid[i]        = 1'b0;
        req_last[i]         = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
      end
    end
  end

  // Monitor: every UART handshake pops one expected byte.
  always @(negedge clk) begin
    logic [7:0] e;
    if (busy) busy_cnt++;
    if (uart_valid && uart_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte actual=%02h expected=none", uart_data);
      end else begin
        e = expq.pop_front();
        chk("uart_byte", {24'h0, uart_data}, {24'h0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int src, input logic [7:0] b, input bit last);
    srcq[src].push_back({last, b});
  endtask

  task automatic expect_bytes(input logic [7:0] b[]);
    foreach (b[i]) expq.push_back(b[i]);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0", expq.size());
      expq.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, n, bad, found;
    logic [3:0] tv;
    rst = 1'b1;
    uart_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_uart_valid", {31'h0, uart_valid}, 32'h0);
    chk("rst_uart_data", {24'h0, uart_data}, 32'h0);
    chk("rst_req_ready", {28'h0, req_ready}, 32'h0);
    chk("rst_grant_id", {30'h0, grant_id}, 32'h0);
    chk("rst_timeout_err", {28'h0, timeout_err}, 32'h0);
    tick();

    // Single 3-byte packet from source 1.
    b0 = busy_cnt;
    send(1, 8'h11, 0); send(1, 8'h22, 0); send(1, 8'h33, 1);
    expect_bytes('{8'hA1, 8'h11, 8'h22, 8'h33});
    wait_drain(50);
    chk("t1_busy_cycles", 32'(busy_cnt - b0), 32'd4);
    chk("t1_grant_id", {30'h0, grant_id}, 32'd1);
    chk("t1_idle_after", {31'h0, busy}, 32'h0);

    // Three competing sources from pointer 0; source 0 waits its turn.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(0, 8'h01, 0); send(0, 8'h02, 1); send(0, 8'h03, 0); send(0, 8'h04, 1);
    send(2, 8'h21, 0); send(2, 8'h22, 1);
    send(3, 8'h31, 0); send(3, 8'h32, 1);
    expect_bytes('{8'hA0, 8'h01, 8'h02, 8'hA2, 8'h21, 8'h22,
                   8'hA3, 8'h31, 8'h32, 8'hA0, 8'h03, 8'h04});
    wait_drain(200);
    chk("t2_grant_id", {30'h0, grant_id}, 32'd0);

    // Backpressure mid-packet; 4-byte packet also ends exactly at MAX_PKT.
    send(1, 8'h51, 0); send(1, 8'h52, 0); send(1, 8'h53, 0); send(1, 8'h54, 1);
    expect_bytes('{8'hA1, 8'h51, 8'h52, 8'h53, 8'h54});
    n = 0;
    while (expq.size() > 2 && n < 100) begin
      tick();
      n++;
    end
    chk("t3_reach_mid", 32'(expq.size()), 32'd2);
    uart_ready = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (uart_valid !== 1'b1 || uart_data !== 8'h53 || timeout_err !== 4'h0 ||
          req_ready !== 4'h0 || busy !== 1'b1) bad++;
    end
    chk("t3_stall_stable", 32'(bad), 32'd0);
    tick();
    uart_ready = 1'b1;
    wait_drain(50);

    // Stall timeout on source 2, then pointer must be 3.
    send(2, 8'h77, 0);
    expect_bytes('{8'hA2, 8'h77});
    wait_drain(50);
    found = 0;
    tv = '0;
    for (int k = 1; k <= 20 && found == 0; k++) begin
      @(negedge clk);
      if (timeout_err !== 4'h0) begin
        found = k;
        tv = timeout_err;
      end
    end
    chk("t4_timeout_cycle", 32'(found), 32'd10);
    chk("t4_timeout_vec", {28'h0, tv}, 32'h4);
    @(negedge clk);
    chk("t4_pulse_end", {28'h0, timeout_err}, 32'h0);
    chk("t4_idle", {31'h0, busy}, 32'h0);
    tick();
    send(3, 8'h3C, 1);
    send(0, 8'h0C, 1);
    expect_bytes('{8'hA3, 8'h3C, 8'hA0, 8'h0C});
    wait_drain(50);

    // Forced release at MAX_PKT with another source served in between.
    send(0, 8'h81, 0); send(0, 8'h82, 0); send(0, 8'h83, 0);
    send(0, 8'h84, 0); send(0, 8'h85, 0); send(0, 8'h86, 1);
    send(1, 8'h91, 0); send(1, 8'h92, 1); send(1, 8'h93, 0); send(1, 8'h94, 1);
    expect_bytes('{8'hA1, 8'h91, 8'h92, 8'hA0, 8'h81, 8'h82, 8'h83, 8'h84,
                   8'hA1, 8'h93, 8'h94, 8'hA0, 8'h85, 8'h86});
    wait_drain(300);

    // Reset in DATA after two bytes; packet restarts with a header.
    send(2, 8'hC1, 0); send(2, 8'hC2, 0); send(2, 8'hC3, 0); send(2, 8'hC4, 1);
    expect_bytes('{8'hA2, 8'hC1, 8'hC2});
    wait_drain(50);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rstcyc_valid", {31'h0, uart_valid}, 32'h0);
    chk("t6_rstcyc_ready", {28'h0, req_ready}, 32'h0);
    tick();
    rst = 1'b0;
    expect_bytes('{8'hA2, 8'hC3, 8'hC4});
    @(negedge clk);
    chk("t6_busy", {31'h0, busy}, 32'h0);
    chk("t6_uart_valid", {31'h0, uart_valid}, 32'h0);
    chk("t6_uart_data", {24'h0, uart_data}, 32'h0);
    chk("t6_req_ready", {28'h0, req_ready}, 32'h0);
    chk("t6_grant_id", {30'h0, grant_id}, 32'h0);
    chk("t6_timeout_err", {28'h0, timeout_err}, 32'h0);
    tick();
    wait_drain(50);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) chk("src_empty", 32'(srcq[i].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
